// File: rtl/std_pkg.sv
// Shared types for the std_* building blocks: counter boundary modes and the
// clock descriptor carried down to storage registers.
package std_pkg;

  typedef enum logic {
    STD_COUNTER_WRAP     = 1'b0,
    STD_COUNTER_SATURATE = 1'b1
  } std_counter_mode_t;

  typedef struct packed {
    logic [15:0] freq_mhz;
    logic [7:0]  domain_id;
  } std_clock_info_t;

endpackage

// File: rtl/std_counter_lane.sv
// One counter lane: up/down by step against an inclusive max, wrap or saturate
// at the boundary, with clear > load > count priority.
module std_counter_lane
  import std_pkg::*;
#(
  parameter std_clock_info_t   CLOCK_INFO   = '0,
  parameter int unsigned       WIDTH        = 8,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter std_counter_mode_t MODE         = STD_COUNTER_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance_i,
  input  logic             down_i,
  input  logic [WIDTH-1:0] step_i,
  input  logic [WIDTH-1:0] max_i,
  input  logic             clear_i,
  input  logic             load_enable_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic [WIDTH-1:0] value_o,
  output logic             complete_o,
  output logic             wrapped_o,
  output logic             event_o
);

  logic [WIDTH-1:0] value_q, value_d;
  logic             wrapped_q, wrapped_d;
  logic [WIDTH:0]   sum;
  logic             boundary;

  always_comb begin
    sum = {1'b0, value_q} + {1'b0, step_i};
    if (down_i) boundary = (value_q < step_i) || (value_q == '0);
    else        boundary = (sum > {1'b0, max_i}) || (value_q >= max_i);

    // A clear or load wins over counting, so it also swallows the event.
    event_o   = advance_i && boundary && !clear_i && !load_enable_i;
    wrapped_d = event_o;

    value_d = value_q;
    if (clear_i) begin
      value_d = RESET_VECTOR;
    end else if (load_enable_i) begin
      value_d = load_value_i;
    end else if (advance_i) begin
      if (!boundary)                     value_d = down_i ? (value_q - step_i) : sum[WIDTH-1:0];
      else if (MODE == STD_COUNTER_WRAP) value_d = down_i ? max_i : '0;
      else                               value_d = down_i ? '0 : max_i;
    end
  end

  std_register #(
    .CLOCK_INFO  (CLOCK_INFO),
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VECTOR)
  ) u_value_reg (
    .clk (clk),
    .rst (rst),
    .d_i (value_d),
    .q_o (value_q)
  );

  std_register #(
    .CLOCK_INFO  (CLOCK_INFO),
    .WIDTH       (1),
    .RESET_VALUE (1'b0)
  ) u_wrapped_reg (
    .clk (clk),
    .rst (rst),
    .d_i (wrapped_d),
    .q_o (wrapped_q)
  );

  assign value_o    = value_q;
  assign wrapped_o  = wrapped_q;
  assign complete_o = down_i ? (value_q == '0) : (value_q == max_i);

endmodule

// File: rtl/std_register.sv
// Generic WIDTH-bit storage register with synchronous active-high reset.
module std_register
  import std_pkg::*;
#(
  parameter std_clock_info_t   CLOCK_INFO  = '0,
  parameter int unsigned       WIDTH       = 1,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  // Clock metadata is informational for timing/CDC tooling; no logic depends on it.
  if (CLOCK_INFO.freq_mhz != '0) begin : g_clk_annotated
  end

  always_ff @(posedge clk) begin
    if (rst) data_q <= RESET_VALUE;
    else     data_q <= d_i;
  end

  assign q_o = data_q;

endmodule

// File: rtl/std_counter_bank.sv
// Bank of CHANNELS independent counter lanes; optionally cascaded so that each
// lane advances only on the previous lane's boundary event.
module std_counter_bank
  import std_pkg::*;
#(
  parameter std_clock_info_t   CLOCK_INFO   = 'b0,
  parameter int unsigned       CHANNELS     = 4,
  parameter int unsigned       WIDTH        = 8,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = 'b0,
  parameter std_counter_mode_t MODE         = STD_COUNTER_WRAP,
  parameter int unsigned       CASCADE      = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       down,
  input  logic [CHANNELS*WIDTH-1:0] step,
  input  logic [CHANNELS*WIDTH-1:0] max,
  input  logic [CHANNELS-1:0]       clear,
  input  logic [CHANNELS-1:0]       load_enable,
  input  logic [CHANNELS*WIDTH-1:0] load_value,
  output logic [CHANNELS*WIDTH-1:0] value,
  output logic [CHANNELS-1:0]       complete,
  output logic [CHANNELS-1:0]       wrapped
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    logic adv;
    logic evt;

    // Per-lane signals (not a shared vector) keep the cascade chain acyclic.
    if (CASCADE == 0 || i == 0) begin : g_adv
      assign adv = enable[i];
    end else begin : g_adv
      assign adv = enable[i] && g_lane[i-1].evt;
    end

    std_counter_lane #(
      .CLOCK_INFO   (CLOCK_INFO),
      .WIDTH        (WIDTH),
      .RESET_VECTOR (RESET_VECTOR),
      .MODE         (MODE)
    ) u_lane (
      .clk           (clk),
      .rst           (rst),
      .advance_i     (adv),
      .down_i        (down[i]),
      .step_i        (step[i*WIDTH +: WIDTH]),
      .max_i         (max[i*WIDTH +: WIDTH]),
      .clear_i       (clear[i]),
      .load_enable_i (load_enable[i]),
      .load_value_i  (load_value[i*WIDTH +: WIDTH]),
      .value_o       (value[i*WIDTH +: WIDTH]),
      .complete_o    (complete[i]),
      .wrapped_o     (wrapped[i]),
      .event_o       (evt)
    );
  end

endmodule

// File: tb/tb_std_counter_bank.sv
// Directed bench for std_counter_bank: wrap, saturate and cascade instances
// driven through hand-computed sequences.
module tb_std_counter_bank;
  import std_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Wrap instance: 4 lanes, reset vector 1
  logic        w_rst;
  logic [3:0]  w_en, w_down, w_clr, w_ld, w_cmp, w_wr;
  logic [31:0] w_step, w_max, w_ldv, w_val;
  // Saturate instance: 1 lane
  logic        s_rst, s_en, s_down, s_clr, s_ld, s_cmp, s_wr;
  logic [7:0]  s_step, s_max, s_ldv, s_val;
  // Cascaded wrap instance: 2 lanes
  logic        c_rst;
  logic [1:0]  c_en, c_down, c_clr, c_ld, c_cmp, c_wr;
  logic [15:0] c_step, c_max, c_ldv, c_val;

  std_counter_bank #(
    .CHANNELS (4), .WIDTH (8), .RESET_VECTOR (8'd1),
    .MODE (STD_COUNTER_WRAP), .CASCADE (0)
  ) u_wrap (
    .clk (clk), .rst (w_rst), .enable (w_en), .down (w_down), .step (w_step),
    .max (w_max), .clear (w_clr), .load_enable (w_ld), .load_value (w_ldv),
    .value (w_val), .complete (w_cmp), .wrapped (w_wr)
  );

  std_counter_bank #(
    .CHANNELS (1), .WIDTH (8), .RESET_VECTOR (8'd0),
    .MODE (STD_COUNTER_SATURATE), .CASCADE (0)
  ) u_sat (
    .clk (clk), .rst (s_rst), .enable (s_en), .down (s_down), .step (s_step),
    .max (s_max), .clear (s_clr), .load_enable (s_ld), .load_value (s_ldv),
    .value (s_val), .complete (s_cmp), .wrapped (s_wr)
  );

  std_counter_bank #(
    .CHANNELS (2), .WIDTH (8), .RESET_VECTOR (8'd0),
    .MODE (STD_COUNTER_WRAP), .CASCADE (1)
  ) u_casc (
    .clk (clk), .rst (c_rst), .enable (c_en), .down (c_down), .step (c_step),
    .max (c_max), .clear (c_clr), .load_enable (c_ld), .load_value (c_ldv),
    .value (c_val), .complete (c_cmp), .wrapped (c_wr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lane8(input logic [31:0] v, input int i);
    return v[i*8 +: 8];
  endfunction

  initial begin
    // Reset with enables and loads active: reset must override them.
    w_rst = 1'b1; w_en = 4'hF; w_down = 4'b1000; w_clr = 4'h0; w_ld = 4'hF;
    w_step = {8'd2, 8'd1, 8'd1, 8'd3};
    w_max  = {8'd20, 8'd7, 8'd1, 8'd10};
    w_ldv  = 32'hAAAA_AAAA;
    s_rst = 1'b1; s_en = 1'b0; s_down = 1'b1; s_clr = 1'b0; s_ld = 1'b0;
    s_step = 8'd4; s_max = 8'd50; s_ldv = 8'd0;
    c_rst = 1'b1; c_en = 2'b00; c_down = 2'b00; c_clr = 2'b00; c_ld = 2'b00;
    c_step = {8'd1, 8'd1}; c_max = {8'd255, 8'd255}; c_ldv = 16'h0000;
    tick();
    chk("w_reset_val", w_val, 32'h0101_0101);
    chk("w_reset_wr",  {28'd0, w_wr}, 32'd0);
    chk("w_reset_cmp", {28'd0, w_cmp}, 32'h2);
    chk("s_reset_val", {24'd0, s_val}, 32'd0);
    chk("s_reset_cmp", {31'd0, s_cmp}, 32'd1);
    chk("c_reset_val", {16'd0, c_val}, 32'd0);

    // Loads
    w_rst = 1'b0; s_rst = 1'b0; c_rst = 1'b0;
    w_en = 4'h0; w_ld = 4'b0111; w_ldv = {8'd0, 8'd7, 8'd200, 8'd0};
    w_max = {8'd20, 8'd7, 8'd100, 8'd10};
    s_ld = 1'b1; s_ldv = 8'd6;
    c_ld = 2'b11; c_ldv = {8'd7, 8'd255};
    tick();
    chk("w_load_val", w_val, 32'h0107_C800);
    chk("w_load_cmp", {28'd0, w_cmp}, 32'h4);
    chk("s_load_val", {24'd0, s_val}, 32'd6);
    chk("c_load_val", {16'd0, c_val}, 32'h07FF);
    w_ld = 4'h0; s_ld = 1'b0; c_ld = 2'b00;

    // Cascade: lane0 wraps 255->0 and lane1 advances 7->8 on the same edge.
    c_en = 2'b11;
    tick();
    chk("c_casc_val", {16'd0, c_val}, 32'h0800);
    chk("c_casc_wr",  {30'd0, c_wr}, 32'h1);
    tick();
    chk("c_casc_hold_val", {16'd0, c_val}, 32'h0801);
    chk("c_casc_hold_wr",  {30'd0, c_wr}, 32'h0);
    c_en = 2'b00;

    // Saturate down from 6 by 4
    s_en = 1'b1;
    tick(); chk("s_dn_2",  {24'd0, s_val}, 32'd2); chk("s_dn_2_wr", {31'd0, s_wr}, 32'd0);
    tick(); chk("s_dn_0",  {24'd0, s_val}, 32'd0); chk("s_dn_0_wr", {31'd0, s_wr}, 32'd1);
    tick(); chk("s_dn_0b", {24'd0, s_val}, 32'd0); chk("s_dn_0b_wr", {31'd0, s_wr}, 32'd1);
    s_en = 1'b0;
    tick(); chk("s_idle_wr", {31'd0, s_wr}, 32'd0);
    // Saturate up by 30 to max 50
    s_down = 1'b0; s_step = 8'd30; s_en = 1'b1;
    tick(); chk("s_up_30", {24'd0, s_val}, 32'd30); chk("s_up_30_wr", {31'd0, s_wr}, 32'd0);
    tick(); chk("s_up_50", {24'd0, s_val}, 32'd50); chk("s_up_50_wr", {31'd0, s_wr}, 32'd1);
    tick(); chk("s_up_50b", {24'd0, s_val}, 32'd50); chk("s_up_50b_wr", {31'd0, s_wr}, 32'd1);
    chk("s_up_cmp", {31'd0, s_cmp}, 32'd1);
    s_en = 1'b0;

    // Wrap lane0: 0,3,6,9,0,3
    w_en = 4'b0001;
    tick(); chk("w0_3", {24'd0, lane8(w_val, 0)}, 32'd3); chk("w0_3_wr", {28'd0, w_wr}, 32'd0);
    tick(); chk("w0_6", {24'd0, lane8(w_val, 0)}, 32'd6);
    tick(); chk("w0_9", {24'd0, lane8(w_val, 0)}, 32'd9); chk("w0_9_wr", {28'd0, w_wr}, 32'd0);
    tick(); chk("w0_0", {24'd0, lane8(w_val, 0)}, 32'd0); chk("w0_0_wr", {28'd0, w_wr}, 32'h1);
    tick(); chk("w0_3b", {24'd0, lane8(w_val, 0)}, 32'd3); chk("w0_3b_wr", {28'd0, w_wr}, 32'd0);

    // Lane1 loaded above max: next up advance wraps
    w_en = 4'b0010;
    tick(); chk("w1_over", {24'd0, lane8(w_val, 1)}, 32'd0); chk("w1_over_wr", {28'd0, w_wr}, 32'h2);
    tick(); chk("w1_next", {24'd0, lane8(w_val, 1)}, 32'd1); chk("w1_next_wr", {28'd0, w_wr}, 32'd0);

    // Lane2 at max with clear + load + enable: reset vector, no pulse
    w_en = 4'b0100; w_clr = 4'b0100; w_ld = 4'b0100; w_ldv = {8'd0, 8'd5, 8'd0, 8'd0};
    tick(); chk("w2_clr", {24'd0, lane8(w_val, 2)}, 32'd1); chk("w2_clr_wr", {28'd0, w_wr}, 32'd0);
    w_clr = 4'h0; w_ld = 4'h0;
    tick(); chk("w2_after", {24'd0, lane8(w_val, 2)}, 32'd2); chk("w2_after_wr", {28'd0, w_wr}, 32'd0);

    // Lane3 down from 1 by 2: wraps to max
    w_en = 4'b1000;
    tick(); chk("w3_wrap", {24'd0, lane8(w_val, 3)}, 32'd20); chk("w3_wrap_wr", {28'd0, w_wr}, 32'h8);
    tick(); chk("w3_18", {24'd0, lane8(w_val, 3)}, 32'd18); chk("w3_18_wr", {28'd0, w_wr}, 32'd0);
    w_en = 4'h0;

    // Reset while lane0 at 9 would otherwise wrap
    w_ld = 4'b0001; w_ldv = {8'd0, 8'd0, 8'd0, 8'd9};
    tick(); chk("w0_ld9", {24'd0, lane8(w_val, 0)}, 32'd9);
    w_ld = 4'h0; w_en = 4'b0001; w_rst = 1'b1;
    tick(); chk("w_rst_val", w_val, 32'h0101_0101); chk("w_rst_wr", {28'd0, w_wr}, 32'd0);
    w_rst = 1'b0;
    tick(); chk("w_resume", {24'd0, lane8(w_val, 0)}, 32'd4); chk("w_resume_wr", {28'd0, w_wr}, 32'd0);
    w_en = 4'h0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
